// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame controller for the UART transmitter. It sequences one frame:
// start bit, WIDTH data bits taken from the external serializer, an optional
// parity bit and a stop bit. One bit is sent per CLK cycle (CLK is the baud
// clock). Back-to-back frames are supported by accepting a new word during
// the stop bit and reloading the serializer in the same edge.
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line idle (high), waiting for Data_valid
//   ST_START  | start bit (low); serializer preloads d0 onto Ser_data
//   ST_DATA   | data bits from serializer, exactly WIDTH cycles
//   ST_PARITY | registered parity bit (only when par_en was set at accept)
//   ST_STOP   | stop bit (high); a new word here starts the next frame
//
// Ports:
//   CLK           in   TX baud clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   Data          in   parallel word, used only for the parity calculation
//   Data_valid    in   single-cycle strobe, new word on Data
//   PAR_EN        in   1 = append parity bit (sampled at accept)
//   PAR_TYP       in   0 = even, 1 = odd parity (sampled at accept)
//   Ser_data      in   current serializer bit (LSB first)
//   Ser_done      in   serializer has presented all WIDTH bits
//   Ser_EN        out  serializer shift enable
//   valid_instop  out  serializer reload strobe during the stop bit
//   Busy          out  frame in progress
//   TX_OUT        out  serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             Data_valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             Ser_data,
    input  logic             Ser_done,
    output logic             Ser_EN,
    output logic             valid_instop,
    output logic             Busy,
    output logic             TX_OUT
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       parity_q;
    logic       parity_d;
    logic       par_en_q;
    logic       par_en_d;
    logic       accept;

    // A word is only taken when no frame is being shifted, or during the stop
    // bit, where it chains straight into the next start bit.
    assign accept = Data_valid & ((state_q == ST_IDLE) | (state_q == ST_STOP));

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        par_en_d = par_en_q;

        if (accept) begin
            // Parity is frozen here so later changes on Data cannot corrupt
            // the frame in flight.
            parity_d = (^Data) ^ PAR_TYP;
            par_en_d = PAR_EN;
        end

        case (state_q)
            ST_IDLE: begin
                if (Data_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (Ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
            ST_STOP: begin
                // A new word wins over returning to idle.
                state_d = Data_valid ? ST_START : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            par_en_q <= par_en_d;
        end
    end

    // Outputs are decoded from the current state so reset forces the idle
    // line level immediately, without waiting for a clock edge.
    always_comb begin
        TX_OUT       = 1'b1;
        Ser_EN       = 1'b0;
        valid_instop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                TX_OUT = 1'b1;
            end
            ST_START: begin
                TX_OUT = 1'b0;
                Ser_EN = 1'b1;
            end
            ST_DATA: begin
                TX_OUT = Ser_data;
                // Stop shifting on the last bit so the serializer never runs
                // past WIDTH.
                Ser_EN = ~Ser_done;
            end
            ST_PARITY: begin
                TX_OUT = parity_q;
            end
            ST_STOP: begin
                TX_OUT       = 1'b1;
                valid_instop = Data_valid;
            end
            default: begin
                TX_OUT = 1'b1;
            end
        endcase
    end

    assign Busy = (state_q != ST_IDLE);

endmodule
